// File: rtl/tlb_op_sequencer.sv
// Sequences TLBP/TLBR/TLBW held in the MEM stage: stalls MEM, runs the TLB transaction, commits to CP0.
// Optional refetch after TLBR/TLBW is enabled by defining TLB_REFETCH_EN.
module tlb_op_sequencer #(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MEM_IsTLBP,
    input  logic             MEM_IsTLBR,
    input  logic             MEM_IsTLBW,
    input  logic             MEM_ExcValid,
    input  logic [31:0]      MEM_PC,
    input  logic             Ext_Stall,
    input  logic             Exc_Flush,
    input  logic [IDX_W-1:0] CP0_Index,
    input  logic             TLB_Ack,
    input  logic             TLB_Hit,
    input  logic [IDX_W-1:0] TLB_HitIdx,
    output logic             TLB_Req,
    output logic [1:0]       TLB_Op,
    output logic [IDX_W-1:0] TLB_Idx,
    output logic             CP0_IndexWr,
    output logic [31:0]      CP0_IndexData,
    output logic             CP0_EntryWr,
    output logic             Seq_Stall,
    output logic             Refetch_Req,
    output logic [31:0]      Refetch_PC,
    output logic             Busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_COMMIT,
        S_HOLD
    } state_t;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_PROBE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b11;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             flush_q, flush_d;
    logic             req_q, req_d;
    logic             index_wr_q, index_wr_d;
    logic             entry_wr_q, entry_wr_d;
    logic [31:0]      index_data_q, index_data_d;
    logic             busy_q, busy_d;

    logic             start;
    logic [1:0]       start_op;

    assign start = (MEM_IsTLBP | MEM_IsTLBR | MEM_IsTLBW) & ~MEM_ExcValid & ~Exc_Flush;

    always_comb begin
        start_op = OP_NONE;
        if (MEM_IsTLBP)      start_op = OP_PROBE;
        else if (MEM_IsTLBR) start_op = OP_READ;
        else if (MEM_IsTLBW) start_op = OP_WRITE;
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        idx_d        = idx_q;
        flush_d      = flush_q;
        req_d        = req_q;
        index_wr_d   = 1'b0;
        entry_wr_d   = 1'b0;
        index_data_d = index_data_q;
        busy_d       = busy_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                    op_d    = start_op;
                    idx_d   = (start_op == OP_PROBE) ? '0 : CP0_Index;
                    flush_d = 1'b0;
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_REQ: begin
                // A flush seen in any REQ cycle is remembered; the request still runs to ack.
                if (Exc_Flush) flush_d = 1'b1;
                if (TLB_Ack) begin
                    req_d = 1'b0;
                    if (flush_q || Exc_Flush) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_COMMIT;
                        if (op_q == OP_PROBE) begin
                            index_wr_d   = 1'b1;
                            index_data_d = {~TLB_Hit, {(31-IDX_W){1'b0}}, TLB_HitIdx};
                        end
                        if (op_q == OP_READ) entry_wr_d = 1'b1;
                    end
                end
            end
            S_COMMIT, S_HOLD: begin
                if (Exc_Flush || !Ext_Stall) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= OP_NONE;
            idx_q        <= '0;
            flush_q      <= 1'b0;
            req_q        <= 1'b0;
            index_wr_q   <= 1'b0;
            entry_wr_q   <= 1'b0;
            index_data_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            idx_q        <= idx_d;
            flush_q      <= flush_d;
            req_q        <= req_d;
            index_wr_q   <= index_wr_d;
            entry_wr_q   <= entry_wr_d;
            index_data_q <= index_data_d;
            busy_q       <= busy_d;
        end
    end

    assign TLB_Req       = req_q;
    assign TLB_Op        = req_q ? op_q : OP_NONE;
    assign TLB_Idx       = req_q ? idx_q : '0;
    assign CP0_IndexWr   = index_wr_q;
    assign CP0_IndexData = index_data_q;
    assign CP0_EntryWr   = entry_wr_q;
    assign Busy          = busy_q;
    // Combinational so the instruction never leaves MEM on the start cycle.
    assign Seq_Stall     = ((state_q == S_IDLE) & start) | (state_q == S_REQ);

`ifdef TLB_REFETCH_EN
    logic [31:0] refetch_pc_q, refetch_pc_d;

    assign refetch_pc_d = ((state_q == S_IDLE) && start) ? (MEM_PC + 32'd4) : refetch_pc_q;

    always_ff @(posedge clk) begin
        if (rst) refetch_pc_q <= '0;
        else     refetch_pc_q <= refetch_pc_d;
    end

    // Pulse on the cycle the instruction leaves MEM; op_q[1] selects TLBR/TLBW.
    assign Refetch_Req = ((state_q == S_COMMIT) || (state_q == S_HOLD)) &
                         ~Ext_Stall & ~Exc_Flush & op_q[1];
    assign Refetch_PC  = refetch_pc_q;
`else
    logic unused_mem_pc;

    assign unused_mem_pc = ^MEM_PC;
    assign Refetch_Req   = 1'b0;
    assign Refetch_PC    = '0;
`endif

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Scoreboard bench for tlb_op_sequencer: the driver also models the TLB and pushes expected events.
module tb_tlb_op_sequencer;

`ifdef TLB_REFETCH_EN
    localparam bit REFETCH = 1'b1;
`else
    localparam bit REFETCH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_IsTLBP, MEM_IsTLBR, MEM_IsTLBW, MEM_ExcValid;
    logic [31:0] MEM_PC;
    logic        Ext_Stall, Exc_Flush;
    logic [3:0]  CP0_Index;
    logic        TLB_Ack, TLB_Hit;
    logic [3:0]  TLB_HitIdx;
    logic        TLB_Req;
    logic [1:0]  TLB_Op;
    logic [3:0]  TLB_Idx;
    logic        CP0_IndexWr;
    logic [31:0] CP0_IndexData;
    logic        CP0_EntryWr, Seq_Stall, Refetch_Req;
    logic [31:0] Refetch_PC;
    logic        Busy;

    tlb_op_sequencer #(.IDX_W(4)) dut (
        .clk(clk), .rst(rst),
        .MEM_IsTLBP(MEM_IsTLBP), .MEM_IsTLBR(MEM_IsTLBR), .MEM_IsTLBW(MEM_IsTLBW),
        .MEM_ExcValid(MEM_ExcValid), .MEM_PC(MEM_PC),
        .Ext_Stall(Ext_Stall), .Exc_Flush(Exc_Flush), .CP0_Index(CP0_Index),
        .TLB_Ack(TLB_Ack), .TLB_Hit(TLB_Hit), .TLB_HitIdx(TLB_HitIdx),
        .TLB_Req(TLB_Req), .TLB_Op(TLB_Op), .TLB_Idx(TLB_Idx),
        .CP0_IndexWr(CP0_IndexWr), .CP0_IndexData(CP0_IndexData),
        .CP0_EntryWr(CP0_EntryWr), .Seq_Stall(Seq_Stall),
        .Refetch_Req(Refetch_Req), .Refetch_PC(Refetch_PC), .Busy(Busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [5:0]  exp_req_q[$];
    logic [31:0] exp_iw_q[$];
    logic [31:0] exp_ew_q[$];
    logic [31:0] exp_rf_q[$];
    logic        req_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every output event is matched against the next expected entry.
    always @(negedge clk) begin
        if (rst) begin
            req_prev = 1'b0;
        end else begin
            if (TLB_Req && !req_prev) begin
                if (exp_req_q.size() == 0) chk("unexpected TLB_Req", {31'b0, TLB_Req}, 32'd0);
                else chk("tlb op/idx", {26'b0, TLB_Op, TLB_Idx}, {26'b0, exp_req_q.pop_front()});
            end
            if (CP0_IndexWr) begin
                if (exp_iw_q.size() == 0) chk("unexpected CP0_IndexWr", {31'b0, CP0_IndexWr}, 32'd0);
                else chk("CP0_IndexData", CP0_IndexData, exp_iw_q.pop_front());
            end
            if (CP0_EntryWr) begin
                if (exp_ew_q.size() == 0) chk("unexpected CP0_EntryWr", {31'b0, CP0_EntryWr}, 32'd0);
                else void'(exp_ew_q.pop_front());
            end
            if (Refetch_Req) begin
                if (exp_rf_q.size() == 0) chk("unexpected Refetch_Req", {31'b0, Refetch_Req}, 32'd0);
                else chk("Refetch_PC", Refetch_PC, exp_rf_q.pop_front());
            end
            req_prev = TLB_Req;
        end
    end

    task automatic clear_inputs();
        MEM_IsTLBP = 0; MEM_IsTLBR = 0; MEM_IsTLBW = 0; MEM_ExcValid = 0;
        Ext_Stall = 0; Exc_Flush = 0; TLB_Ack = 0; TLB_Hit = 0; TLB_HitIdx = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " outputs"}, {TLB_Req, TLB_Op, TLB_Idx, CP0_IndexWr, CP0_EntryWr,
                                Seq_Stall, Refetch_Req, Busy}, 32'd0);
        chk({tag, " IndexData"}, CP0_IndexData, 32'd0);
        chk({tag, " Refetch_PC"}, Refetch_PC, 32'd0);
    endtask

    // fmode: 0 none, 1 flush on start cycle, 2 flush in first REQ cycle, 3 flush in COMMIT
    task automatic run_txn(input bit p, input bit r, input bit w, input bit ev,
                           input logic [31:0] pc, input logic [3:0] cidx, input int ack_dly,
                           input bit hit, input logic [3:0] hidx, input int stall, input int fmode);
        bit         start, exp_rf;
        logic [1:0] op;
        logic [3:0] idx;
        int         n;
        start  = (p | r | w) && !ev && fmode != 1;
        op     = p ? 2'd1 : r ? 2'd2 : w ? 2'd3 : 2'd0;
        idx    = p ? 4'd0 : cidx;
        exp_rf = REFETCH && op != 2'd1 && fmode == 0;
        if (start) begin
            exp_req_q.push_back({op, idx});
            if (fmode != 2 && op == 2'd1) exp_iw_q.push_back((hit ? 32'd0 : 32'h8000_0000) | {28'd0, hidx});
            if (fmode != 2 && op == 2'd2) exp_ew_q.push_back(pc);
            if (exp_rf) exp_rf_q.push_back(pc + 32'd4);
        end

        @(posedge clk); #1;
        MEM_IsTLBP = p; MEM_IsTLBR = r; MEM_IsTLBW = w; MEM_ExcValid = ev;
        MEM_PC = pc; CP0_Index = cidx; Exc_Flush = (fmode == 1); Ext_Stall = 0;
        @(negedge clk);
        chk("Seq_Stall start cycle", {31'b0, Seq_Stall}, {31'b0, start});
        if (!start) begin
            @(posedge clk); #1; clear_inputs();
            @(negedge clk);
            chk("no start TLB_Req", {31'b0, TLB_Req}, 32'd0);
            chk("no start Busy", {31'b0, Busy}, 32'd0);
            return;
        end

        @(posedge clk); #1;
        if (fmode == 2) Exc_Flush = 1;
        for (int d = 0; d <= ack_dly; d++) begin
            @(negedge clk);
            chk("REQ TLB_Req/Seq_Stall/Busy", {29'b0, TLB_Req, Seq_Stall, Busy}, 32'd7);
            chk("REQ TLB_Op stable", {30'b0, TLB_Op}, {30'b0, op});
            if (d == ack_dly) begin
                TLB_Ack = 1; TLB_Hit = hit; TLB_HitIdx = hidx;
            end
            @(posedge clk); #1;
            TLB_Ack = 0; Exc_Flush = 0;
        end

        if (fmode == 2) begin
            clear_inputs();
            @(negedge clk);
            chk("flushed REQ exit", {28'b0, Busy, TLB_Req, CP0_IndexWr, CP0_EntryWr}, 32'd0);
            chk("flushed REQ refetch", {31'b0, Refetch_Req}, 32'd0);
            return;
        end

        n = (fmode == 3) ? 0 : stall;
        Exc_Flush = (fmode == 3);
        for (int s = 0; s <= n; s++) begin
            Ext_Stall = (s < n);
            @(negedge clk);
            chk("COMMIT/HOLD Seq_Stall/TLB_Req", {30'b0, Seq_Stall, TLB_Req}, 32'd0);
            chk("COMMIT/HOLD Busy", {31'b0, Busy}, 32'd1);
            chk("Refetch_Req timing", {31'b0, Refetch_Req}, {31'b0, (s == n) ? exp_rf : 1'b0});
            @(posedge clk); #1;
        end
        clear_inputs();
        @(negedge clk);
        chk("exit Busy/Refetch", {30'b0, Busy, Refetch_Req}, 32'd0);
    endtask

    task automatic rst_in_req(input logic [31:0] pc);
        exp_req_q.push_back({2'd1, 4'd0});
        @(posedge clk); #1;
        MEM_IsTLBP = 1; MEM_PC = pc; CP0_Index = 4'd6;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst test REQ", {31'b0, TLB_Req}, 32'd1);
        @(posedge clk); #1;
        rst = 1; clear_inputs();
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("after mid-REQ reset", {29'b0, TLB_Req, Busy, Seq_Stall}, 32'd0);
        chk("after mid-REQ reset TLB_Op", {30'b0, TLB_Op}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; clear_inputs(); MEM_PC = 0; CP0_Index = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        #1 rst = 0;
        @(negedge clk);
        chk_all_zero("post reset");

        run_txn(1, 0, 0, 0, 32'h0000_1000, 4'd3, 1, 1, 4'd5, 0, 0);
        run_txn(1, 0, 0, 0, 32'h0000_2000, 4'd3, 0, 0, 4'd0, 0, 0);
        run_txn(0, 0, 1, 0, 32'hBFC0_0100, 4'd9, 0, 0, 4'd0, 0, 0);
        run_txn(0, 1, 0, 0, 32'h8000_0040, 4'd7, 0, 0, 4'd0, 3, 0);
        run_txn(0, 0, 1, 1, 32'h8000_0080, 4'd2, 0, 0, 4'd0, 0, 0);
        run_txn(0, 0, 1, 0, 32'h8000_00C0, 4'd4, 2, 0, 4'd0, 0, 2);
        rst_in_req(32'h0000_3000);
        run_txn(1, 0, 0, 0, 32'h0000_3004, 4'd1, 1, 1, 4'd12, 0, 0);
        run_txn(0, 0, 1, 0, 32'hFFFF_FFFC, 4'd15, 0, 0, 4'd0, 1, 0);
        run_txn(0, 1, 0, 0, 32'h0000_4000, 4'd8, 0, 0, 4'd0, 0, 1);
        run_txn(1, 0, 0, 0, 32'h0000_5000, 4'd8, 1, 1, 4'd3, 0, 3);
        run_txn(1, 1, 1, 0, 32'h0000_6000, 4'd10, 0, 0, 4'd0, 0, 0);

        for (int i = 0; i < 200; i++) begin
            int fm;
            logic [31:0] pc;
            fm = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
            pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0), pc, 4'($urandom), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 4'($urandom), int'($urandom_range(0, 3)), fm);
        end

        repeat (2) @(negedge clk);
        chk("leftover TLB_Req events", exp_req_q.size(), 32'd0);
        chk("leftover CP0_IndexWr events", exp_iw_q.size(), 32'd0);
        chk("leftover CP0_EntryWr events", exp_ew_q.size(), 32'd0);
        chk("leftover Refetch events", exp_rf_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
